// File: rtl/cpu_types_pkg.sv
// Shared CPU types: control bundle carried into EX, scoreboard entries,
// opcode/funct encodings and the immediate-extension helper.
package cpu_types_pkg;

  localparam int CPU_WORD_W = 32;
  localparam int CPU_REG_W  = 5;

  // HALT sits at 0x3E; 0x3F is deliberately left unassigned and decodes as illegal.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3E;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU, ALU_LUI
  } aluop_t;

  typedef enum logic [2:0] {
    PC_SEQ, PC_BEQ, PC_BNE, PC_JUMP, PC_JR
  } pcsrc_t;

  typedef struct packed {
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [CPU_REG_W-1:0]  rs;
    logic [CPU_REG_W-1:0]  rt;
    logic [CPU_REG_W-1:0]  dest;
    logic [CPU_REG_W-1:0]  shamt;
    logic [CPU_WORD_W-1:0] imm_ext;
    logic [25:0]           addr;
    aluop_t                ALUOp;
    logic                  ALUsrc;
    logic                  RegWr;
    logic                  dREN;
    logic                  dWEN;
    logic                  MemToReg;
    pcsrc_t                PCsrc;
    logic                  branch;
    logic                  jump;
    logic                  halt;
    logic                  illegal;
  } ctrl_t;

  typedef struct packed {
    logic                 valid;
    logic [CPU_REG_W-1:0] dest;
    logic                 is_load;
  } sb_entry_t;

  function automatic logic [CPU_WORD_W-1:0] ext_imm(input logic [15:0] imm, input logic zero_ext);
    ext_imm = zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/pcu_scoreboard.sv
// In-flight destination tracker: a shift array of sb_entry_t, slot 0 being
// the instruction now in EX, with a combinational RAW match against ID sources.
module pcu_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int SB_DEPTH = 3,
  parameter bit FORWARD  = 1'b1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 i_freeze,
  input  sb_entry_t            i_push,
  input  logic [CPU_REG_W-1:0] i_rs,
  input  logic [CPU_REG_W-1:0] i_rt,
  input  logic                 i_rd_rs,
  input  logic                 i_rd_rt,
  output logic                 o_match
);

  sb_entry_t            r_slot [SB_DEPTH];
  logic [SB_DEPTH-1:0]  w_hit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < SB_DEPTH; k++) r_slot[k] <= '0;
    end else if (!i_freeze) begin
      r_slot[0] <= i_push;
      for (int k = 1; k < SB_DEPTH; k++) r_slot[k] <= r_slot[k-1];
    end
  end

  // With forwarding only a load still in EX cannot supply its result in time.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_hit[k] = r_slot[k].valid && (r_slot[k].dest != 5'd0) &&
                 ((i_rd_rs && (r_slot[k].dest == i_rs)) ||
                  (i_rd_rt && (r_slot[k].dest == i_rt))) &&
                 (!FORWARD || ((k == 0) && r_slot[k].is_load));
    end
  end

  assign o_match = |w_hit;

endmodule

// File: rtl/pipe_control_unit.sv
// ID-stage decoder feeding the ID/EX control register, with hazard stall,
// squash on taken branch, whole-block freeze on MEM stall and sticky halt.
module pipe_control_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = CPU_WORD_W,
  parameter int REG_W    = CPU_REG_W,
  parameter int SB_DEPTH = 3,
  parameter bit FORWARD  = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instr,
  input  logic              ihit,
  input  logic              mem_stall,
  input  logic              flush,
  output ctrl_t             ex_ctrl,
  output logic              ex_valid,
  output logic              stall_if,
  output logic              iREN,
  output logic              halt
);

  logic [5:0]       w_op, w_funct;
  logic [REG_W-1:0] w_rs, w_rt, w_rd, w_sh;
  logic [15:0]      w_imm;
  ctrl_t            w_dec;
  logic             w_rd_rs, w_rd_rt;
  logic             w_hz, w_issue, w_stall, w_halt_set, w_halted;
  sb_entry_t        w_push;
  ctrl_t            r_ex_ctrl;
  logic             r_ex_valid, r_halt;

  assign w_op    = instr[31:26];
  assign w_rs    = instr[25:21];
  assign w_rt    = instr[20:16];
  assign w_rd    = instr[15:11];
  assign w_sh    = instr[10:6];
  assign w_funct = instr[5:0];
  assign w_imm   = instr[15:0];

  always_comb begin
    w_dec         = '0;
    w_dec.opcode  = w_op;
    w_dec.funct   = w_funct;
    w_dec.rs      = w_rs;
    w_dec.rt      = w_rt;
    w_dec.shamt   = w_sh;
    w_dec.addr    = instr[25:0];
    w_dec.dest    = w_rt;
    w_dec.imm_ext = ext_imm(w_imm, 1'b0);
    w_dec.ALUOp   = ALU_ADD;
    w_dec.PCsrc   = PC_SEQ;
    w_rd_rs       = 1'b0;
    w_rd_rt       = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_dec.dest  = w_rd;
        w_dec.RegWr = 1'b1;
        w_rd_rs     = 1'b1;
        w_rd_rt     = 1'b1;
        case (w_funct)
          FN_ADD, FN_ADDU: w_dec.ALUOp = ALU_ADD;
          FN_SUB, FN_SUBU: w_dec.ALUOp = ALU_SUB;
          FN_AND:          w_dec.ALUOp = ALU_AND;
          FN_OR:           w_dec.ALUOp = ALU_OR;
          FN_XOR:          w_dec.ALUOp = ALU_XOR;
          FN_NOR:          w_dec.ALUOp = ALU_NOR;
          FN_SLT:          w_dec.ALUOp = ALU_SLT;
          FN_SLTU:         w_dec.ALUOp = ALU_SLTU;
          FN_SLL: begin w_dec.ALUOp = ALU_SLL; w_rd_rs = 1'b0; end
          FN_SRL: begin w_dec.ALUOp = ALU_SRL; w_rd_rs = 1'b0; end
          FN_JR: begin
            w_dec.RegWr = 1'b0;
            w_dec.jump  = 1'b1;
            w_dec.PCsrc = PC_JR;
            w_rd_rt     = 1'b0;
          end
          default: begin
            w_dec.illegal = 1'b1;
            w_dec.RegWr   = 1'b0;
            w_rd_rs       = 1'b0;
            w_rd_rt       = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        w_dec.ALUsrc = 1'b1;
        w_dec.RegWr  = 1'b1;
        w_rd_rs      = 1'b1;
        w_dec.ALUOp  = (w_op == OP_SLTI)  ? ALU_SLT  :
                       (w_op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_dec.ALUsrc  = 1'b1;
        w_dec.RegWr   = 1'b1;
        w_rd_rs       = 1'b1;
        w_dec.imm_ext = ext_imm(w_imm, 1'b1);
        w_dec.ALUOp   = (w_op == OP_ANDI) ? ALU_AND :
                        (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        w_dec.ALUsrc  = 1'b1;
        w_dec.RegWr   = 1'b1;
        w_dec.ALUOp   = ALU_LUI;
        w_dec.imm_ext = {w_imm, 16'h0000};
      end
      OP_LW: begin
        w_dec.ALUsrc   = 1'b1;
        w_dec.RegWr    = 1'b1;
        w_dec.dREN     = 1'b1;
        w_dec.MemToReg = 1'b1;
        w_rd_rs        = 1'b1;
      end
      OP_SW: begin
        w_dec.ALUsrc = 1'b1;
        w_dec.dWEN   = 1'b1;
        w_rd_rs      = 1'b1;
        w_rd_rt      = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_dec.ALUOp  = ALU_SUB;
        w_dec.branch = 1'b1;
        w_dec.PCsrc  = (w_op == OP_BEQ) ? PC_BEQ : PC_BNE;
        w_rd_rs      = 1'b1;
        w_rd_rt      = 1'b1;
      end
      OP_J: begin
        w_dec.jump  = 1'b1;
        w_dec.PCsrc = PC_JUMP;
      end
      OP_JAL: begin
        w_dec.jump  = 1'b1;
        w_dec.PCsrc = PC_JUMP;
        w_dec.RegWr = 1'b1;
        w_dec.dest  = 5'd31;
      end
      OP_HALT: w_dec.halt = 1'b1;
      default: w_dec.illegal = 1'b1;
    endcase
  end

  pcu_scoreboard #(.SB_DEPTH(SB_DEPTH), .FORWARD(FORWARD)) u_sb (
    .CLK      (CLK),
    .nRST     (nRST),
    .i_freeze (mem_stall),
    .i_push   (w_push),
    .i_rs     (w_dec.rs),
    .i_rt     (w_dec.rt),
    .i_rd_rs  (w_rd_rs),
    .i_rd_rt  (w_rd_rt),
    .o_match  (w_hz)
  );

  // A HALT leaving EX also blocks whatever sits behind it in ID on the same edge.
  assign w_halt_set = r_ex_valid & r_ex_ctrl.halt & ~flush & ~mem_stall;
  assign w_halted   = r_halt | w_halt_set;

  always_comb begin
    w_issue = 1'b0;
    w_stall = 1'b0;
    if (mem_stall) begin
      w_stall = 1'b1;
    end else if (w_halted || flush) begin
      w_stall = 1'b0;
    end else if (w_hz && ihit) begin
      w_stall = 1'b1;
    end else begin
      w_issue = ihit;
    end
  end

  assign w_push = '{valid: w_issue & w_dec.RegWr, dest: w_dec.dest, is_load: w_dec.dREN};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ex_ctrl  <= '0;
      r_ex_valid <= 1'b0;
      r_halt     <= 1'b0;
    end else begin
      r_halt <= r_halt | w_halt_set;
      if (!mem_stall) begin
        r_ex_valid <= w_issue;
        r_ex_ctrl  <= w_issue ? w_dec : '0;
      end
    end
  end

  assign ex_ctrl  = r_ex_ctrl;
  assign ex_valid = r_ex_valid;
  assign halt     = r_halt;
  assign iREN     = ~r_halt;
  assign stall_if = w_stall;

endmodule
